// File: rtl/dac_adc_1val_pkg.sv
// Shared types and constants for the single-shot DAC-write / ADC-read sequencer.
package dac_adc_1val_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int ADC_RES_BITS = 12;

    typedef enum logic [2:0] {
        IDLE,
        DAC_XFER,
        SETTLE,
        ADC_XFER,
        DONE
    } state_e;

endpackage

// File: rtl/dac_adc_1val_spi_frame_master.sv
// Generic mode-0 SPI frame engine: one FRAME_BITS frame per start, MSB first,
// CLK_DIV system clocks per SCLK half-period; done_o marks the frame-ending edge.
module spi_frame_master #(
    parameter int CLK_DIV     = 25,
    parameter int FRAME_BITS  = 16,
    parameter bit SAMPLE_FALL = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] tx_word_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_o,
    output logic [FRAME_BITS-1:0] rx_word_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic                  tc;
    logic                  last_bit;

    assign tc       = (cnt_q == '0);
    assign last_bit = (bit_q == BIT_W'(FRAME_BITS - 1));

    always_comb begin
        cs_d   = cs_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        if (cs_q) begin
            if (start_i) begin
                cs_d   = 1'b0;
                sclk_d = 1'b0;
                mosi_d = tx_word_i[FRAME_BITS-1];
                tx_d   = tx_word_i;
                cnt_d  = CNT_W'(CLK_DIV - 1);
                bit_d  = '0;
            end
        end else if (!tc) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = CNT_W'(CLK_DIV - 1);
            if (!sclk_q) begin
                sclk_d = 1'b1;
                if (!SAMPLE_FALL) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], miso_i};
                end
            end else begin
                sclk_d = 1'b0;
                if (SAMPLE_FALL) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], miso_i};
                end
                // The last falling edge also closes the frame on the same clock.
                if (last_bit) begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                end else begin
                    bit_d  = bit_q + 1'b1;
                    mosi_d = tx_q[FRAME_BITS-2];
                    tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            cs_q   <= cs_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_o      = cs_q;
    assign rx_word_o = rx_q;
    assign busy_o    = ~cs_q;
    assign done_o    = ~cs_q & tc & sclk_q & last_bit;

endmodule

// File: rtl/dac_adc_1val.sv
// Single-shot sequencer: DAC write, settle wait, ADC read, result + eoconv pulse.
// Define ADC_SAMPLE_FALL_EN to sample miso_adc_i on the sck_o falling-edge clock.
module dac_adc_1val
    import dac_adc_1val_pkg::*;
#(
    parameter int                    CLK_DIV    = 25,
    parameter logic [FRAME_BITS-1:0] DAC_WORD   = 16'h3800,
    parameter logic [FRAME_BITS-1:0] ADC_CMD    = 16'hC000,
    parameter int                    SETTLE_CYC = 100
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    miso_adc_i,
    output logic                    mosi_dac_o,
    output logic                    dclk_o,
    output logic                    cs_dac_o,
    output logic                    mosi_adc_o,
    output logic                    sck_o,
    output logic                    cs_adc_o,
    output logic [ADC_RES_BITS-1:0] dout_o,
    output logic                    eoconv_o
);

`ifdef ADC_SAMPLE_FALL_EN
    localparam bit ADC_SAMPLE_FALL = 1'b1;
`else
    localparam bit ADC_SAMPLE_FALL = 1'b0;
`endif

    localparam int TMR_W = $clog2(SETTLE_CYC + 1);

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [ADC_RES_BITS-1:0] dout_q, dout_d;
    logic                    eoconv_q, eoconv_d;
    logic                    dac_start, adc_start;
    logic                    dac_busy, adc_busy;
    logic                    dac_done, adc_done;
    logic [FRAME_BITS-1:0]   dac_rx, adc_rx;
    logic                    unused_bits;

    spi_frame_master #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .SAMPLE_FALL(1'b0)
    ) u_dac_spi (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (dac_start),
        .tx_word_i(DAC_WORD),
        .miso_i   (1'b0),
        .sclk_o   (dclk_o),
        .mosi_o   (mosi_dac_o),
        .cs_o     (cs_dac_o),
        .rx_word_o(dac_rx),
        .busy_o   (dac_busy),
        .done_o   (dac_done)
    );

    spi_frame_master #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .SAMPLE_FALL(ADC_SAMPLE_FALL)
    ) u_adc_spi (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (adc_start),
        .tx_word_i(ADC_CMD),
        .miso_i   (miso_adc_i),
        .sclk_o   (sck_o),
        .mosi_o   (mosi_adc_o),
        .cs_o     (cs_adc_o),
        .rx_word_o(adc_rx),
        .busy_o   (adc_busy),
        .done_o   (adc_done)
    );

    // The DAC link never receives, and only the low result bits of the ADC frame matter.
    assign unused_bits = ^{dac_rx, adc_rx[FRAME_BITS-1:ADC_RES_BITS]};

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dout_d    = dout_q;
        eoconv_d  = 1'b0;
        dac_start = 1'b0;
        adc_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !dac_busy && !adc_busy) begin
                    dac_start = 1'b1;
                    state_d   = DAC_XFER;
                end
            end
            DAC_XFER: begin
                if (dac_done) begin
                    state_d = SETTLE;
                    timer_d = TMR_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    adc_start = 1'b1;
                    state_d   = ADC_XFER;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ADC_XFER: begin
                if (adc_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dout_d   = adc_rx[ADC_RES_BITS-1:0];
                eoconv_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            dout_q   <= '0;
            eoconv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dout_q   <= dout_d;
            eoconv_q <= eoconv_d;
        end
    end

    assign dout_o   = dout_q;
    assign eoconv_o = eoconv_q;

endmodule

// File: tb/tb_dac_adc_1val.sv
// Directed bench for dac_adc_1val: frame timing, captured SPI bits, result, busy and reset behaviour.
module tb_dac_adc_1val;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        miso_const = 1'b0;
    logic        use_pat = 1'b0;
    logic [15:0] pattern = 16'h0000;
    logic        miso_adc_i;
    logic        mosi_dac_o, dclk_o, cs_dac_o;
    logic        mosi_adc_o, sck_o, cs_adc_o;
    logic [11:0] dout_o;
    logic        eoconv_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    int          dac_edges = 0, adc_edges = 0, adc_falls = 0, eoc_cnt = 0, overlap_cnt = 0;
    logic [15:0] dac_bits = 16'h0, adc_bits = 16'h0;
    int          fall_base = 0;
    int          pat_idx;

    int   r_dac_low, r_adc_low, r_gap, r_lat;
    logic r_eoc_after;
    int   b_dac_e, b_adc_e, b_eoc;

    dac_adc_1val dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .miso_adc_i(miso_adc_i),
        .mosi_dac_o(mosi_dac_o),
        .dclk_o    (dclk_o),
        .cs_dac_o  (cs_dac_o),
        .mosi_adc_o(mosi_adc_o),
        .sck_o     (sck_o),
        .cs_adc_o  (cs_adc_o),
        .dout_o    (dout_o),
        .eoconv_o  (eoconv_o)
    );

    always #5 clk_i = ~clk_i;

    // ADC model: bit 15 valid at CS fall, next bit after each SCK falling edge.
    assign pat_idx    = ((adc_falls - fall_base) > 15) ? 15 : (adc_falls - fall_base);
    assign miso_adc_i = use_pat ? pattern[15 - pat_idx] : miso_const;

    always @(posedge dclk_o) begin
        dac_edges = dac_edges + 1;
        dac_bits  = {dac_bits[14:0], mosi_dac_o};
    end

    always @(posedge sck_o) begin
        adc_edges = adc_edges + 1;
        adc_bits  = {adc_bits[14:0], mosi_adc_o};
    end

    always @(negedge sck_o) adc_falls = adc_falls + 1;

    always @(negedge clk_i) begin
        if (eoconv_o) eoc_cnt = eoc_cnt + 1;
        if (!cs_dac_o && !cs_adc_o) overlap_cnt = overlap_cnt + 1;
    end

    task automatic run_sequence(input logic miso_v, input bit pulse_busy);
        miso_const  = miso_v;
        fall_base   = adc_falls;
        b_dac_e     = dac_edges;
        b_adc_e     = adc_edges;
        b_eoc       = eoc_cnt;
        r_dac_low   = 0;
        r_adc_low   = 0;
        r_gap       = 0;
        r_lat       = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk_i);
            if (n == 1) start_i = 1'b0;
            if (pulse_busy && (n == 1200 || n == 1701)) start_i = 1'b1;
            if (pulse_busy && (n == 1201 || n == 1702)) start_i = 1'b0;
            if (!cs_dac_o) r_dac_low++;
            if (!cs_adc_o) r_adc_low++;
            if (r_dac_low > 0 && r_adc_low == 0 && cs_dac_o && cs_adc_o) r_gap++;
            if (eoconv_o) begin
                r_lat = n;
                break;
            end
        end
        start_i = 1'b0;
        @(negedge clk_i);
        r_eoc_after = eoconv_o;
        repeat (100) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #5;
        total_cnt++; if (cs_dac_o !== 1'b1) $display("FAIL reset_cs_dac: got %b want 1", cs_dac_o); else pass_cnt++;
        total_cnt++; if (cs_adc_o !== 1'b1) $display("FAIL reset_cs_adc: got %b want 1", cs_adc_o); else pass_cnt++;
        total_cnt++; if (dclk_o !== 1'b0) $display("FAIL reset_dclk: got %b want 0", dclk_o); else pass_cnt++;
        total_cnt++; if (sck_o !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck_o); else pass_cnt++;
        total_cnt++; if (mosi_dac_o !== 1'b0) $display("FAIL reset_mosi_dac: got %b want 0", mosi_dac_o); else pass_cnt++;
        total_cnt++; if (mosi_adc_o !== 1'b0) $display("FAIL reset_mosi_adc: got %b want 0", mosi_adc_o); else pass_cnt++;
        total_cnt++; if (dout_o !== 12'h000) $display("FAIL reset_dout: got %h want 000", dout_o); else pass_cnt++;
        total_cnt++; if (eoconv_o !== 1'b0) $display("FAIL reset_eoconv: got %b want 0", eoconv_o); else pass_cnt++;
        #5;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_dac_frame();
        run_sequence(1'b1, 1'b0);
        total_cnt++; if (r_dac_low !== 800) $display("FAIL dac_cs_low_cycles: got %0d want 800", r_dac_low); else pass_cnt++;
        total_cnt++; if (dac_edges - b_dac_e !== 16) $display("FAIL dac_dclk_edges: got %0d want 16", dac_edges - b_dac_e); else pass_cnt++;
        total_cnt++; if (dac_bits !== 16'h3800) $display("FAIL dac_word: got %h want 3800", dac_bits); else pass_cnt++;
        total_cnt++; if (overlap_cnt !== 0) $display("FAIL cs_overlap: got %0d want 0", overlap_cnt); else pass_cnt++;
    endtask

    task automatic test_adc_read();
        total_cnt++; if (r_gap !== 100) $display("FAIL settle_gap: got %0d want 100", r_gap); else pass_cnt++;
        total_cnt++; if (r_adc_low !== 800) $display("FAIL adc_cs_low_cycles: got %0d want 800", r_adc_low); else pass_cnt++;
        total_cnt++; if (adc_edges - b_adc_e !== 16) $display("FAIL adc_sck_edges: got %0d want 16", adc_edges - b_adc_e); else pass_cnt++;
        total_cnt++; if (adc_bits !== 16'hC000) $display("FAIL adc_cmd: got %h want c000", adc_bits); else pass_cnt++;
        total_cnt++; if (r_lat !== 1702) $display("FAIL latency_ones: got %0d want 1702", r_lat); else pass_cnt++;
        total_cnt++; if (dout_o !== 12'hFFF) $display("FAIL dout_ones: got %h want fff", dout_o); else pass_cnt++;
        total_cnt++; if (r_eoc_after !== 1'b0) $display("FAIL eoconv_width: got %b want 0", r_eoc_after); else pass_cnt++;
        total_cnt++; if (eoc_cnt - b_eoc !== 1) $display("FAIL eoconv_count: got %0d want 1", eoc_cnt - b_eoc); else pass_cnt++;
    endtask

    task automatic test_second_start();
        repeat (600) @(negedge clk_i);
        run_sequence(1'b0, 1'b0);
        total_cnt++; if (dac_bits !== 16'h3800) $display("FAIL dac_word_2nd: got %h want 3800", dac_bits); else pass_cnt++;
        total_cnt++; if (r_dac_low !== 800) $display("FAIL dac_cs_low_2nd: got %0d want 800", r_dac_low); else pass_cnt++;
        total_cnt++; if (dout_o !== 12'h000) $display("FAIL dout_zeros: got %h want 000", dout_o); else pass_cnt++;
        total_cnt++; if (r_lat !== 1702) $display("FAIL latency_zeros: got %0d want 1702", r_lat); else pass_cnt++;
        total_cnt++; if (eoc_cnt - b_eoc !== 1) $display("FAIL eoconv_count_2nd: got %0d want 1", eoc_cnt - b_eoc); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        run_sequence(1'b1, 1'b1);
        repeat (2000) @(negedge clk_i);
        total_cnt++; if (r_lat !== 1702) $display("FAIL latency_busy: got %0d want 1702", r_lat); else pass_cnt++;
        total_cnt++; if (dout_o !== 12'hFFF) $display("FAIL dout_busy: got %h want fff", dout_o); else pass_cnt++;
        total_cnt++; if (eoc_cnt - b_eoc !== 1) $display("FAIL eoconv_count_busy: got %0d want 1", eoc_cnt - b_eoc); else pass_cnt++;
        total_cnt++; if (dac_edges - b_dac_e !== 16) $display("FAIL extra_dac_frame: got %0d edges want 16", dac_edges - b_dac_e); else pass_cnt++;
        total_cnt++; if (adc_edges - b_adc_e !== 16) $display("FAIL extra_adc_frame: got %0d edges want 16", adc_edges - b_adc_e); else pass_cnt++;
    endtask

    task automatic test_pattern();
        pattern = 16'hA5C3;
        use_pat = 1'b1;
        run_sequence(1'b0, 1'b0);
        use_pat = 1'b0;
        total_cnt++; if (dout_o !== 12'h5C3) $display("FAIL dout_pattern: got %h want 5c3", dout_o); else pass_cnt++;
        total_cnt++; if (r_lat !== 1702) $display("FAIL latency_pattern: got %0d want 1702", r_lat); else pass_cnt++;
    endtask

    task automatic test_reset_mid_dac();
        b_eoc = eoc_cnt;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (300) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        total_cnt++; if (cs_dac_o !== 1'b1) $display("FAIL midrst_cs_dac: got %b want 1", cs_dac_o); else pass_cnt++;
        total_cnt++; if (cs_adc_o !== 1'b1) $display("FAIL midrst_cs_adc: got %b want 1", cs_adc_o); else pass_cnt++;
        total_cnt++; if (dclk_o !== 1'b0) $display("FAIL midrst_dclk: got %b want 0", dclk_o); else pass_cnt++;
        total_cnt++; if (sck_o !== 1'b0) $display("FAIL midrst_sck: got %b want 0", sck_o); else pass_cnt++;
        total_cnt++; if (dout_o !== 12'h000) $display("FAIL midrst_dout: got %h want 000", dout_o); else pass_cnt++;
        total_cnt++; if (mosi_dac_o !== 1'b0) $display("FAIL midrst_mosi_dac: got %b want 0", mosi_dac_o); else pass_cnt++;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2000) @(negedge clk_i);
        total_cnt++; if (eoc_cnt - b_eoc !== 0) $display("FAIL midrst_eoconv: got %0d want 0", eoc_cnt - b_eoc); else pass_cnt++;
        total_cnt++; if (cs_dac_o !== 1'b1) $display("FAIL midrst_idle_cs_dac: got %b want 1", cs_dac_o); else pass_cnt++;
        run_sequence(1'b1, 1'b0);
        total_cnt++; if (dac_bits !== 16'h3800) $display("FAIL postrst_dac_word: got %h want 3800", dac_bits); else pass_cnt++;
        total_cnt++; if (r_lat !== 1702) $display("FAIL postrst_latency: got %0d want 1702", r_lat); else pass_cnt++;
        total_cnt++; if (dout_o !== 12'hFFF) $display("FAIL postrst_dout: got %h want fff", dout_o); else pass_cnt++;
        total_cnt++; if (eoc_cnt - b_eoc !== 1) $display("FAIL postrst_eoconv: got %0d want 1", eoc_cnt - b_eoc); else pass_cnt++;
        total_cnt++; if (overlap_cnt !== 0) $display("FAIL cs_overlap_final: got %0d want 0", overlap_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dac_frame();
        test_adc_read();
        test_second_start();
        test_busy_ignore();
        test_pattern();
        test_reset_mid_dac();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
